// File: rtl/neuron_feeder_if.sv
// Bus between the neuron feeder and its surroundings: vector write port, start/busy,
// neuron-side pair stream and captured result. result_q8 exists only with NEURON_FEEDER_SAT8_EN.
interface neuron_feeder_if #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 8,
  parameter int Y_W      = 18
);
  localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic signed [DATA_W-1:0] wr_x;
  logic signed [DATA_W-1:0] wr_w;
  logic                     start;
  logic                     busy;
  logic                     acc_clr;
  logic signed [DATA_W-1:0] x_out;
  logic signed [DATA_W-1:0] w_out;
  logic                     out_valid;
  logic signed [Y_W-1:0]    y_in;
  logic signed [Y_W-1:0]    result;
  logic                     result_valid;
`ifdef NEURON_FEEDER_SAT8_EN
  logic signed [DATA_W-1:0] result_q8;
`endif

  modport master (
    output wr_en, wr_addr, wr_x, wr_w, start, y_in,
    input  busy, acc_clr, x_out, w_out, out_valid, result, result_valid
`ifdef NEURON_FEEDER_SAT8_EN
    , input result_q8
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_w, start, y_in,
    output busy, acc_clr, x_out, w_out, out_valid, result, result_valid
`ifdef NEURON_FEEDER_SAT8_EN
    , output result_q8
`endif
  );
endinterface

// File: rtl/neuron_feeder.sv
// Sequencer that streams a stored (x, w) vector into the pipelined neuron and captures y.
// Optional saturated next-layer output result_q8 is enabled by defining NEURON_FEEDER_SAT8_EN.
module neuron_feeder #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 8,
  parameter int Y_W      = 18,
  parameter int LATENCY  = 4
) (
  input logic            clk,
  input logic            rst,
  neuron_feeder_if.slave bus
);
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] x_arr [N_INPUTS];
  logic signed [DATA_W-1:0] w_arr [N_INPUTS];

  logic                     busy_q, acc_clr_q, out_valid_q, result_valid_q;
  logic signed [DATA_W-1:0] x_q, w_q;
  logic signed [Y_W-1:0]    result_q;

  logic                     acc_clr_d, out_valid_d, capture, wr_ok;
  logic signed [DATA_W-1:0] x_d, w_d;

  assign idx_inc = idx_q + IDX_W'(1);
  assign wr_ok   = (state_q == IDLE) && bus.wr_en &&
                   ({1'b0, bus.wr_addr} < (IDX_W+1)'(N_INPUTS));

  // Next-state logic also computes the values the output registers take on the next edge.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    acc_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    capture     = 1'b0;
    x_d         = '0;
    w_d         = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CLEAR;
          acc_clr_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d     = STREAM;
        idx_d       = '0;
        x_d         = x_arr[0];
        w_d         = w_arr[0];
        out_valid_d = 1'b1;
      end
      STREAM: begin
        if (idx_q == IDX_W'(N_INPUTS - 1)) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(LATENCY);
        end else begin
          idx_d       = idx_inc;
          x_d         = x_arr[idx_inc];
          w_d         = w_arr[idx_inc];
          out_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      acc_clr_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      result_valid_q <= 1'b0;
      x_q            <= '0;
      w_q            <= '0;
      result_q       <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        x_arr[i] <= '0;
        w_arr[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      busy_q         <= (state_d != IDLE);
      acc_clr_q      <= acc_clr_d;
      out_valid_q    <= out_valid_d;
      result_valid_q <= capture;
      x_q            <= x_d;
      w_q            <= w_d;
      if (capture) result_q <= bus.y_in;
      // The array write lands on the same edge that samples start, so CLEAR already sees it.
      if (wr_ok) begin
        x_arr[bus.wr_addr] <= bus.wr_x;
        w_arr[bus.wr_addr] <= bus.wr_w;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.result_valid = result_valid_q;
  assign bus.x_out        = x_q;
  assign bus.w_out        = w_q;
  assign bus.result       = result_q;

`ifdef NEURON_FEEDER_SAT8_EN
  localparam logic signed [Y_W-1:0] SAT_MAX = Y_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [Y_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_W-1:0] q8_d, q8_q;

  always_comb begin
    if (bus.y_in > SAT_MAX)      q8_d = SAT_MAX[DATA_W-1:0];
    else if (bus.y_in < SAT_MIN) q8_d = SAT_MIN[DATA_W-1:0];
    else                         q8_d = bus.y_in[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q8_q <= '0;
    else if (capture) q8_q <= q8_d;
  end

  assign bus.result_q8 = q8_q;
`endif
endmodule

// File: tb/tb_neuron_feeder.sv
// Scoreboard bench for neuron_feeder: expected pairs/results are queued when driven
// and popped when the DUT presents them. Define NEURON_FEEDER_SAT8_EN to also check result_q8.
module tb_neuron_feeder;
  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int YW   = 18;
  localparam int LAT  = 4;
  localparam int AW   = $clog2(N);
  localparam int LAST = N + LAT + 3;

  typedef struct packed {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] w;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_feeder_if #(.N_INPUTS(N), .DATA_W(DW), .Y_W(YW)) nf ();

  neuron_feeder #(.N_INPUTS(N), .DATA_W(DW), .Y_W(YW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (nf)
  );

  pair_t                exp_pairs[$];
  logic signed [YW-1:0] exp_res[$];
  logic signed [DW-1:0] mx [N];
  logic signed [DW-1:0] mw [N];
  logic signed [YW-1:0] last_result = '0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int clr_cyc = 0;
  int prev_clr_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic signed [DW-1:0] sat8(input logic signed [YW-1:0] v);
    if (v > 127)       return 8'sd127;
    else if (v < -128) return -8'sd128;
    else               return v[DW-1:0];
  endfunction

  task automatic write_word(input int a, input logic signed [DW-1:0] x, input logic signed [DW-1:0] w);
    nf.wr_en   = 1'b1;
    nf.wr_addr = AW'(a);
    nf.wr_x    = x;
    nf.wr_w    = w;
    mx[a] = x;
    mw[a] = w;
    @(posedge clk); #1;
    nf.wr_en = 1'b0;
  endtask

  // Entered during the cycle in which start is high; checks every cycle of one run.
  task automatic run(input logic signed [YW-1:0] yval, input bit inject, input bit chain);
    pair_t p;
    for (int i = 0; i < N; i++) exp_pairs.push_back({mx[i], mw[i]});
    @(posedge clk); #1;
    for (int c = 1; c <= LAST; c++) begin
      nf.start   = (inject && c == 4) || (chain && c == LAST);
      nf.wr_en   = inject && c == 4;
      nf.wr_addr = AW'(3);
      nf.wr_x    = 8'sd99;
      nf.wr_w    = -8'sd99;
      if (c == N + LAT + 1) begin
        nf.y_in = yval;
        exp_res.push_back(yval);
      end else begin
        nf.y_in = '0;
      end
      @(negedge clk);
      vectors++;
      if (nf.acc_clr !== (c == 1)) begin
        miscompares++;
        $display("[TB] FAIL acc_clr c=%0d: got %b expected %b", c, nf.acc_clr, (c == 1));
      end
      if (nf.acc_clr === 1'b1) begin
        prev_clr_cyc = clr_cyc;
        clr_cyc      = cyc;
      end
      vectors++;
      if (nf.busy !== (c <= N + LAT + 2)) begin
        miscompares++;
        $display("[TB] FAIL busy c=%0d: got %b expected %b", c, nf.busy, (c <= N + LAT + 2));
      end
      vectors++;
      if (nf.out_valid !== (c >= 2 && c <= N + 1)) begin
        miscompares++;
        $display("[TB] FAIL out_valid c=%0d: got %b expected %b", c, nf.out_valid, (c >= 2 && c <= N + 1));
      end
      vectors++;
      if (nf.out_valid === 1'b1) begin
        if (exp_pairs.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL pair c=%0d: got x=%0d w=%0d expected no pair", c, nf.x_out, nf.w_out);
        end else begin
          p = exp_pairs.pop_front();
          if (nf.x_out !== p.x || nf.w_out !== p.w) begin
            miscompares++;
            $display("[TB] FAIL pair c=%0d: got x=%0d w=%0d expected x=%0d w=%0d",
                     c, nf.x_out, nf.w_out, p.x, p.w);
          end
        end
      end else if (nf.x_out !== '0 || nf.w_out !== '0) begin
        miscompares++;
        $display("[TB] FAIL idle_pair c=%0d: got x=%0d w=%0d expected 0 0", c, nf.x_out, nf.w_out);
      end
      vectors++;
      if (nf.result_valid !== (c == N + LAT + 2)) begin
        miscompares++;
        $display("[TB] FAIL result_valid c=%0d: got %b expected %b", c, nf.result_valid, (c == N + LAT + 2));
      end
      vectors++;
      if (nf.result_valid === 1'b1) begin
        if (exp_res.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL result c=%0d: got %0d expected no result", c, nf.result);
        end else begin
          last_result = exp_res.pop_front();
          if (nf.result !== last_result) begin
            miscompares++;
            $display("[TB] FAIL result c=%0d: got %0d expected %0d", c, nf.result, last_result);
          end
`ifdef NEURON_FEEDER_SAT8_EN
          vectors++;
          if (nf.result_q8 !== sat8(last_result)) begin
            miscompares++;
            $display("[TB] FAIL result_q8 c=%0d: got %0d expected %0d", c, nf.result_q8, sat8(last_result));
          end
`endif
        end
      end else if (nf.result !== last_result) begin
        miscompares++;
        $display("[TB] FAIL result_hold c=%0d: got %0d expected %0d", c, nf.result, last_result);
      end
      if (c < LAST) begin
        @(posedge clk); #1;
      end
    end
    nf.wr_en = 1'b0;
    vectors++;
    if (exp_pairs.size() != 0 || exp_res.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pairs %0d results left expected 0 0",
               exp_pairs.size(), exp_res.size());
      exp_pairs.delete();
      exp_res.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (nf.busy !== 1'b0 || nf.acc_clr !== 1'b0 || nf.out_valid !== 1'b0 || nf.result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_flags: got busy=%b clr=%b ov=%b rv=%b expected all 0",
               tag, nf.busy, nf.acc_clr, nf.out_valid, nf.result_valid);
    end
    vectors++;
    if (nf.x_out !== '0 || nf.w_out !== '0 || nf.result !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s_data: got x=%0d w=%0d result=%0d expected 0 0 0", tag, nf.x_out, nf.w_out, nf.result);
    end
`ifdef NEURON_FEEDER_SAT8_EN
    vectors++;
    if (nf.result_q8 !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s_q8: got %0d expected 0", tag, nf.result_q8);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nf.wr_en = 1'b0; nf.wr_addr = '0; nf.wr_x = '0; nf.wr_w = '0;
    nf.start = 1'b0; nf.y_in = '0;
    for (int i = 0; i < N; i++) begin mx[i] = '0; mw[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_load_stream();
    for (int i = 0; i < N - 1; i++)
      write_word(i, DW'(i + 1), (i % 2 == 0) ? DW'(-(i + 1)) : DW'(i + 1));
    nf.wr_en   = 1'b1;
    nf.wr_addr = AW'(N - 1);
    nf.wr_x    = DW'(N);
    nf.wr_w    = DW'(N);
    mx[N-1] = DW'(N);
    mw[N-1] = DW'(N);
    nf.start = 1'b1;
    run(18'sd300, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_traffic();
    @(posedge clk); #1;
    nf.start = 1'b1;
    run(-18'sd1000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    nf.start = 1'b1;
    run(-18'sd5, 1'b0, 1'b1);
    run(18'sd12345, 1'b0, 1'b0);
    vectors++;
    if (clr_cyc - prev_clr_cyc != N + LAT + 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_clr_gap: got %0d expected %0d", clr_cyc - prev_clr_cyc, N + LAT + 3);
    end
  endtask

  task automatic test_reset_abort();
    write_word(0, 8'sd50, -8'sd60);
    nf.start = 1'b1;
    @(posedge clk); #1;
    nf.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    for (int i = 0; i < N; i++) begin mx[i] = '0; mw[i] = '0; end
    last_result = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < LAST; c++) begin
      @(negedge clk);
      vectors++;
      if (nf.result_valid !== 1'b0 || nf.busy !== 1'b0 || nf.out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_quiet c=%0d: got rv=%b busy=%b ov=%b expected 0 0 0",
                 c, nf.result_valid, nf.busy, nf.out_valid);
      end
      @(posedge clk); #1;
    end
    nf.start = 1'b1;
    run(18'sd7, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_stream();
    test_ignored_traffic();
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
